// File: rtl/jtag_tap_sequencer.sv
// Command-driven JTAG master: turns TAP-reset / IR / DR / run-idle commands into TCK/TMS/TDI slots and collects TDO.
// Define JTAG_SEQ_TRST_EN to add a TRST pulse ahead of the INIT and TAP_RESET TMS sequences.
module jtag_tap_sequencer #(
    parameter int TCK_DIV = 2,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_type_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_data_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               rsp_err_o,
    output logic               busy_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i,
    output logic               trst_o
);

`ifdef JTAG_SEQ_TRST_EN
    localparam bit TRST_EN = 1'b1;
`else
    localparam bit TRST_EN = 1'b0;
`endif

    localparam int DIV_W  = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int TRST_W = $clog2(2 * TCK_DIV + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TCK_DIV - 1);
    localparam logic [TRST_W-1:0] TRST_LAST = TRST_W'(2 * TCK_DIV);
    localparam logic [TRST_W-1:0] TRST_ONE  = TRST_W'(1);
    localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  CNT_0     = LEN_W'(0);
    localparam logic [LEN_W-1:0]  CNT_1     = LEN_W'(1);
    localparam logic [LEN_W-1:0]  CNT_2     = LEN_W'(2);
    localparam logic [LEN_W-1:0]  CNT_6     = LEN_W'(6);

    typedef enum logic [3:0] {
        INIT, IDLE, RST_SEQ, SEL, CAPTURE, SHIFT, EXIT, UPDATE, RTI_RUN, RESP
    } state_t;

    state_t               state;
    state_t               nxt_state;
    logic [LEN_W-1:0]     slot_cnt;
    logic [LEN_W-1:0]     nxt_cnt;
    logic                 nxt_tms;
    logic                 nxt_shift;
    logic [DIV_W-1:0]     div_cnt;
    logic                 trst_ph;
    logic [TRST_W-1:0]    trst_cnt;
    logic                 trst_q;
    logic [LEN_W-1:0]     len_q;
    logic [MAX_LEN-1:0]   data_q;
    logic [MAX_LEN-1:0]   cap_mask;

    assign trst_o = trst_q;

    // slot_cnt counts remaining slots of the current state, including the one in flight;
    // this block describes the slot that starts when the current one ends.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = slot_cnt - CNT_1;
        nxt_tms   = 1'b0;
        nxt_shift = 1'b0;
        if (slot_cnt > CNT_1) begin
            case (state)
                INIT, RST_SEQ: nxt_tms = (slot_cnt > CNT_2);
                SEL:           nxt_tms = 1'b1;
                SHIFT: begin
                    nxt_tms   = (slot_cnt == CNT_2);
                    nxt_shift = 1'b1;
                end
                default:       nxt_tms = 1'b0;
            endcase
        end else begin
            case (state)
                INIT:    nxt_state = IDLE;
                SEL: begin
                    nxt_state = CAPTURE;
                    nxt_cnt   = CNT_2;
                end
                CAPTURE: begin
                    nxt_state = SHIFT;
                    nxt_cnt   = len_q;
                    nxt_tms   = (len_q == CNT_1);
                    nxt_shift = 1'b1;
                end
                SHIFT: begin
                    nxt_state = EXIT;
                    nxt_cnt   = CNT_1;
                    nxt_tms   = 1'b1;
                end
                EXIT: begin
                    nxt_state = UPDATE;
                    nxt_cnt   = CNT_1;
                end
                default: nxt_state = RESP;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= INIT;
            slot_cnt    <= CNT_6;
            div_cnt     <= '0;
            trst_ph     <= TRST_EN;
            trst_cnt    <= '0;
            trst_q      <= 1'b0;
            len_q       <= '0;
            data_q      <= '0;
            cap_mask    <= '0;
            tck_o       <= 1'b0;
            tms_o       <= 1'b1;
            tdi_o       <= 1'b0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            busy_o      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        rsp_data_o  <= '0;
                        rsp_err_o   <= 1'b0;
                        data_q      <= cmd_data_i;
                        len_q       <= cmd_len_i;
                        cap_mask    <= MAX_LEN'(1);
                        div_cnt     <= '0;
                        tck_o       <= 1'b0;
                        tdi_o       <= 1'b0;
                        case (cmd_type_i)
                            2'd0: begin
                                state    <= RST_SEQ;
                                slot_cnt <= CNT_6;
                                tms_o    <= 1'b1;
                                trst_ph  <= TRST_EN;
                                trst_cnt <= '0;
                            end
                            2'd1, 2'd2: begin
                                if (cmd_len_i == CNT_0 || cmd_len_i > MAX_LEN_L) begin
                                    state       <= RESP;
                                    rsp_valid_o <= 1'b1;
                                    rsp_err_o   <= 1'b1;
                                end else begin
                                    state    <= SEL;
                                    slot_cnt <= (cmd_type_i == 2'd1) ? CNT_2 : CNT_1;
                                    tms_o    <= 1'b1;
                                end
                            end
                            default: begin
                                if (cmd_len_i == CNT_0) begin
                                    state       <= RESP;
                                    rsp_valid_o <= 1'b1;
                                end else begin
                                    state    <= RTI_RUN;
                                    slot_cnt <= cmd_len_i;
                                    tms_o    <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    if (trst_ph) begin
                        // The first slot's low phase starts on the clk TRST drops.
                        if (trst_cnt == TRST_LAST) begin
                            trst_q  <= 1'b0;
                            trst_ph <= 1'b0;
                            div_cnt <= '0;
                        end else begin
                            trst_q   <= 1'b1;
                            trst_cnt <= trst_cnt + TRST_ONE;
                        end
                    end else if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!tck_o) begin
                            tck_o <= 1'b1;
                            if (state == SHIFT) begin
                                rsp_data_o <= rsp_data_o | (tdo_i ? cap_mask : '0);
                                cap_mask   <= cap_mask << 1;
                            end
                        end else begin
                            tck_o    <= 1'b0;
                            state    <= nxt_state;
                            slot_cnt <= nxt_cnt;
                            tms_o    <= nxt_tms;
                            tdi_o    <= nxt_shift & data_q[0];
                            if (nxt_shift) begin
                                data_q <= data_q >> 1;
                            end
                            if (nxt_state == RESP) begin
                                rsp_valid_o <= 1'b1;
                            end
                            if (nxt_state == IDLE) begin
                                cmd_ready_o <= 1'b1;
                                busy_o      <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
